// File: rtl/attopu_mem_responder.sv
// attopu_mem_responder: memory-side responder for the attopu single-cycle core.
// One word-addressed RAM serves both the instruction-fetch and the data port.
// A single LED register is mapped at LED_ADDR. A byte-stream loader fills RAM
// while it holds the core in reset through cpuHold.
// Build option: define LOADER_CHECKSUM_EN to require a trailing XOR checksum
// byte after the data words. Without it, ldError is tied low.
module attopu_mem_responder #(
    parameter int          ADDR_BITS = 8,
    parameter logic [15:0] LED_ADDR  = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] iAddr,
    output logic [15:0] iDataOut,
    input  logic [15:0] dAddr,
    input  logic        dWE,
    input  logic [15:0] dDataIn,
    output logic [15:0] dDataOut,
    input  logic        ldStart,
    input  logic        ldValid,
    input  logic [7:0]  ldData,
    output logic        ldReady,
    output logic        cpuHold,
    output logic        ldError,
    output logic [7:0]  led
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CNT_LO = 3'd1,
        CNT_HI = 3'd2,
        DAT_LO = 3'd3,
        DAT_HI = 3'd4,
        DONE   = 3'd5,
        CHECK  = 3'd6
    } ldState_t;

`ifdef LOADER_CHECKSUM_EN
    // With checksum enabled, the stream ends in CHECK, which still accepts a byte.
    localparam ldState_t END_ST    = CHECK;
    localparam logic     END_READY = 1'b1;
`else
    localparam ldState_t END_ST    = DONE;
    localparam logic     END_READY = 1'b0;
`endif

    logic [15:0]          mem [DEPTH];
    ldState_t             state;
    logic [ADDR_BITS-1:0] wrPtr;
    logic [15:0]          remaining;
    logic [7:0]           cntLo;
    logic [7:0]           datLo;
    logic                 byteXfer;
    logic                 coreWr;
    logic                 memWe;
    logic [ADDR_BITS-1:0] memWAddr;
    logic [15:0]          memWData;
    logic [15:0]          cntWord;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]           csum;
    logic                 ldErrorQ;
`endif

    // Only the low address bits select a word; the upper bits alias.
    logic unusedIAddrHi;
    assign unusedIAddrHi = ^iAddr[15:ADDR_BITS];

    assign byteXfer = ldValid & ldReady;
    assign coreWr   = dWE & ~cpuHold;
    assign cntWord  = {ldData, cntLo};

    // Zero-latency reads. The LED register shadows only the data port.
    assign iDataOut = mem[iAddr[ADDR_BITS-1:0]];
    assign dDataOut = (dAddr == LED_ADDR) ? {8'h00, led} : mem[dAddr[ADDR_BITS-1:0]];

    // Single RAM write port. The loader owns it in DAT_HI; the core is held then.
    always_comb begin
        memWe    = 1'b0;
        memWAddr = dAddr[ADDR_BITS-1:0];
        memWData = dDataIn;
        if (state == DAT_HI && byteXfer) begin
            memWe    = 1'b1;
            memWAddr = wrPtr;
            memWData = {ldData, datLo};
        end else if (coreWr && dAddr != LED_ADDR) begin
            memWe = 1'b1;
        end
    end

    // RAM array: no reset, so contents survive reset and an aborted load.
    always_ff @(posedge clk) begin
        if (memWe) mem[memWAddr] <= memWData;
    end

    // LED register, written by the core only while it is running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          led <= 8'h00;
        else if (coreWr && dAddr == LED_ADDR) led <= dDataIn[7:0];
    end

    // Loader FSM with registered ldReady/cpuHold/ldError.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cpuHold   <= 1'b0;
            ldReady   <= 1'b0;
            wrPtr     <= '0;
            remaining <= '0;
            cntLo     <= '0;
            datLo     <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum      <= '0;
            ldErrorQ  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (ldStart) begin
                        state   <= CNT_LO;
                        cpuHold <= 1'b1;
                        ldReady <= 1'b1;
                        wrPtr   <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum     <= '0;
                        ldErrorQ <= 1'b0;
`endif
                    end
                end
                CNT_LO: begin
                    if (byteXfer) begin
                        cntLo <= ldData;
                        state <= CNT_HI;
                    end
                end
                CNT_HI: begin
                    if (byteXfer) begin
                        remaining <= cntWord;
                        if (cntWord == 16'd0) begin
                            state   <= END_ST;
                            ldReady <= END_READY;
                        end else begin
                            state <= DAT_LO;
                        end
                    end
                end
                DAT_LO: begin
                    if (byteXfer) begin
                        datLo <= ldData;
                        state <= DAT_HI;
`ifdef LOADER_CHECKSUM_EN
                        csum  <= csum ^ ldData;
`endif
                    end
                end
                DAT_HI: begin
                    if (byteXfer) begin
                        // The word itself is written by the RAM port above.
                        wrPtr     <= wrPtr + 1'b1;
                        remaining <= remaining - 16'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum      <= csum ^ ldData;
`endif
                        if (remaining == 16'd1) begin
                            state   <= END_ST;
                            ldReady <= END_READY;
                        end else begin
                            state <= DAT_LO;
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK: begin
                    if (byteXfer) begin
                        ldReady <= 1'b0;
                        if (ldData == csum) begin
                            state <= DONE;
                        end else begin
                            // Bad image: keep the core held until a fresh load.
                            ldErrorQ <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
`endif
                DONE: begin
                    state   <= IDLE;
                    cpuHold <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    cpuHold <= 1'b0;
                    ldReady <= 1'b0;
                end
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    assign ldError = ldErrorQ;
`else
    assign ldError = 1'b0;
`endif

endmodule

// File: tb/tb_attopu_mem_responder.sv
// Bench for attopu_mem_responder: constant vector table for the data port,
// random core traffic and random loads against an array/queue model of RAM.
module tb_attopu_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] iAddr = '0, dAddr = '0, dDataIn = '0;
    logic        dWE = 1'b0, ldStart = 1'b0, ldValid = 1'b0;
    logic [7:0]  ldData = '0;
    logic [15:0] iDataOut, dDataOut;
    logic        ldReady, cpuHold, ldError;
    logic [7:0]  led;

    attopu_mem_responder dut (
        .clk(clk), .rst_n(rst_n), .iAddr(iAddr), .iDataOut(iDataOut),
        .dAddr(dAddr), .dWE(dWE), .dDataIn(dDataIn), .dDataOut(dDataOut),
        .ldStart(ldStart), .ldValid(ldValid), .ldData(ldData),
        .ldReady(ldReady), .cpuHold(cpuHold), .ldError(ldError), .led(led)
    );

    always #5 clk = ~clk;

    int          nCmp = 0;
    int          nErr = 0;
    logic [15:0] refMem [256];
    logic [7:0]  refLed = 8'h00;
    logic [15:0] fixedW [$];

    typedef struct {
        logic        we;
        logic [15:0] addr, wdata, iaddr, expPre, expPost, expI;
        logic [7:0]  expLed;
    } vec_t;
    vec_t vt [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Full RAM readback through both ports; dWE must be low.
    task automatic sweep(input string nm);
        for (int a = 0; a < 256; a++) begin
            iAddr = 16'(a) | (16'($urandom_range(0, 255)) << 8);
            dAddr = 16'(a) | (16'($urandom_range(0, 254)) << 8);
            #1;
            chk({nm, "_iram"}, {16'h0, iDataOut}, {16'h0, refMem[a]});
            chk({nm, "_dram"}, {16'h0, dDataOut}, {16'h0, refMem[a]});
        end
        iAddr = '0; dAddr = '0;
        step();
    endtask

    // One program load of n words; sumOvr >= 0 forces the checksum byte.
    task automatic doLoad(input string nm, input int n, input bit bp, input int sumOvr);
        logic [15:0] words [$];
        logic [7:0]  bytes [$];
        logic [7:0]  cs;
        int          sent, guard;
        bit          rdy, badSum;
        cs = 8'h00; sent = 0; guard = 0; badSum = 0;
        for (int i = 0; i < n; i++)
            words.push_back(fixedW.size() > i ? fixedW[i] : 16'($urandom));
        bytes.push_back(n[7:0]);
        bytes.push_back(n[15:8]);
        foreach (words[i]) begin
            bytes.push_back(words[i][7:0]);
            bytes.push_back(words[i][15:8]);
            cs = cs ^ words[i][7:0] ^ words[i][15:8];
        end
`ifdef LOADER_CHECKSUM_EN
        if (sumOvr >= 0) begin
            bytes.push_back(8'(sumOvr));
            badSum = (8'(sumOvr) != cs);
        end else begin
            bytes.push_back(cs);
        end
`else
        if (sumOvr >= 0) badSum = 0;
`endif
        ldStart = 1'b1;
        step();
        ldStart = 1'b0;
        chk({nm, "_start_hold"}, {31'h0, cpuHold}, 32'd1);
        chk({nm, "_start_ready"}, {31'h0, ldReady}, 32'd1);
        chk({nm, "_start_err"}, {31'h0, ldError}, 32'd0);
        while (sent < bytes.size() && guard < 2000) begin
            ldValid = bp ? (guard % 2 == 0) : 1'b1;
            ldData  = bytes[sent];
            if (bp) begin
                // Core write and stray ldStart while held must both be ignored.
                dWE = 1'b1; dAddr = 16'h0000; dDataIn = 16'hDEAD;
                ldStart = (sent + 1 < bytes.size());
            end
            rdy = ldReady;
            step();
            guard++;
            if (ldValid && rdy) sent++;
        end
        ldValid = 1'b0; dWE = 1'b0; ldStart = 1'b0;
        chk({nm, "_bytes_taken"}, 32'(sent), 32'(bytes.size()));
        for (int k = 0; k < n; k++) refMem[k % 256] = words[k];
        chk({nm, "_end_hold"}, {31'h0, cpuHold}, 32'd1);
        chk({nm, "_end_ready"}, {31'h0, ldReady}, 32'd0);
        chk({nm, "_end_err"}, {31'h0, ldError}, {31'h0, badSum});
        step();
        chk({nm, "_release"}, {31'h0, cpuHold}, {31'h0, badSum});
        sweep(nm);
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_hold", {31'h0, cpuHold}, 32'd0);
        chk("rst_ready", {31'h0, ldReady}, 32'd0);
        chk("rst_err", {31'h0, ldError}, 32'd0);
        chk("rst_led", {24'h0, led}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        step();

        // Fill RAM with a known pattern through the data port
        for (int i = 0; i < 256; i++) begin
            dWE = 1'b1; dAddr = 16'(i); dDataIn = 16'hA000 | 16'(i);
            refMem[i] = 16'hA000 | 16'(i);
            step();
        end
        dWE = 1'b0;

        vt[0] = '{1'b1, 16'hFFFF, 16'h12A5, 16'h0000, 16'h0000, 16'h00A5, 16'hA000, 8'hA5};
        vt[1] = '{1'b1, 16'h0010, 16'hBEEF, 16'h0010, 16'hA010, 16'hBEEF, 16'hBEEF, 8'hA5};
        vt[2] = '{1'b0, 16'h0110, 16'h0000, 16'h0110, 16'hBEEF, 16'hBEEF, 16'hBEEF, 8'hA5};
        vt[3] = '{1'b1, 16'h0110, 16'hCAFE, 16'h0210, 16'hBEEF, 16'hCAFE, 16'hCAFE, 8'hA5};
        vt[4] = '{1'b1, 16'hFFFF, 16'h0000, 16'h0011, 16'h00A5, 16'h0000, 16'hA011, 8'h00};
        vt[5] = '{1'b0, 16'h00FF, 16'h0000, 16'hFFFF, 16'hA0FF, 16'hA0FF, 16'hA0FF, 8'h00};
        foreach (vt[v]) begin
            dWE = vt[v].we; dAddr = vt[v].addr; dDataIn = vt[v].wdata; iAddr = vt[v].iaddr;
            #1;
            chk($sformatf("vec%0d_pre", v), {16'h0, dDataOut}, {16'h0, vt[v].expPre});
            step();
            dWE = 1'b0;
            chk($sformatf("vec%0d_post", v), {16'h0, dDataOut}, {16'h0, vt[v].expPost});
            chk($sformatf("vec%0d_iout", v), {16'h0, iDataOut}, {16'h0, vt[v].expI});
            chk($sformatf("vec%0d_led", v), {24'h0, led}, {24'h0, vt[v].expLed});
            if (vt[v].we) begin
                if (vt[v].addr == 16'hFFFF) refLed = vt[v].wdata[7:0];
                else refMem[vt[v].addr[7:0]] = vt[v].wdata;
            end
        end

        // Random core traffic
        for (int k = 0; k < 200; k++) begin
            logic [15:0] a, w;
            logic        we;
            a  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            w  = 16'($urandom);
            we = 1'($urandom_range(0, 1));
            dAddr = a; dWE = we; dDataIn = w; iAddr = 16'($urandom);
            #1;
            chk("rnd_dout", {16'h0, dDataOut}, {16'h0, (a == 16'hFFFF) ? {8'h00, refLed} : refMem[a[7:0]]});
            chk("rnd_iout", {16'h0, iDataOut}, {16'h0, refMem[iAddr[7:0]]});
            step();
            if (we) begin
                if (a == 16'hFFFF) refLed = w[7:0];
                else refMem[a[7:0]] = w;
            end
            chk("rnd_led", {24'h0, led}, {24'h0, refLed});
        end
        dWE = 1'b0; dAddr = '0;

        // Loads: fixed two-word image, with backpressure, zero count, wrap, random
        fixedW = {16'h1234, 16'h5678};
        doLoad("load2", 2, 1'b0, -1);
        chk("load2_w0", {16'h0, refMem[0]}, 32'h1234);
        doLoad("load2bp", 2, 1'b1, -1);
        fixedW.delete();
        doLoad("zero", 0, 1'b0, -1);
        doLoad("wrap", 257, 1'b0, -1);
        for (int r = 0; r < 4; r++)
            doLoad($sformatf("rload%0d", r), $urandom_range(1, 8), 1'($urandom_range(0, 1)), -1);

        // Async reset after three data bytes
        begin
            logic [7:0] mid [5];
            mid = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78};
            ldStart = 1'b1;
            step();
            ldStart = 1'b0;
            foreach (mid[i]) begin
                ldValid = 1'b1; ldData = mid[i];
                step();
            end
            ldValid = 1'b0;
            #2 rst_n = 1'b0;
            #1;
            chk("arst_hold", {31'h0, cpuHold}, 32'd0);
            chk("arst_ready", {31'h0, ldReady}, 32'd0);
            chk("arst_err", {31'h0, ldError}, 32'd0);
            refMem[0] = 16'h1234;
            iAddr = 16'h0000;
            #1;
            chk("arst_ram0", {16'h0, iDataOut}, 32'h1234);
            @(negedge clk) rst_n = 1'b1;
            step();
            sweep("arst");
        end

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum keeps the core held; a new good load recovers
        fixedW = {16'h0001};
        doLoad("csbad", 1, 1'b0, 0);
        fixedW.delete();
        doLoad("csgood", 3, 1'b0, -1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule

// File: doc/attopu_mem_responder.md
Name: attopu_mem_responder

Overview:
- Memory-side responder for the attopu single-cycle core. It serves the core's instruction-fetch port and data port from one word-addressed RAM array.
- It decodes one memory-mapped LED register.
- It contains a byte-stream program loader FSM. The loader holds the core in reset while it fills RAM.
- Sits between the core's iAddr/dAddr/dWE/dDataIn bus and the board, replacing the bare memory.

Parameters:
- ADDR_BITS, 8, RAM depth is 2**ADDR_BITS 16-bit words; higher address bits alias.
- LED_ADDR, 16'hFFFF, data-port address of the LED register.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- iAddr  in  16  instruction fetch address (core PC).
- iDataOut  out  16  instruction word.
- dAddr  in  16  data address.
- dWE  in  1  data write enable.
- dDataIn  in  16  data write value.
- dDataOut  out  16  data read value.
- ldStart  in  1  single-cycle pulse, begins a program load.
- ldValid  in  1  loader byte valid.
- ldData  in  8  loader byte.
- ldReady  out  1  loader accepts byte this cycle.
- cpuHold  out  1  drive to the core's reset; 1 = core held.
- ldError  out  1  checksum error flag (see Optional Feature).
- led  out  8  LED register.

Behaviour:
- Reset (rst_n low, async): FSM to IDLE.
  - cpuHold=0, ldReady=0, ldError=0, led=8'h00, write pointer=0, byte/word counters=0.
  - RAM contents are not cleared.
- Reads are combinational, zero latency:
  - iDataOut = RAM[iAddr[ADDR_BITS-1:0]].
  - dDataOut = {8'h00, led} when dAddr==LED_ADDR, else RAM[dAddr[ADDR_BITS-1:0]].
- Data writes commit at the rising edge when dWE=1 and cpuHold=0.
  - dAddr==LED_ADDR writes dDataIn[7:0] to led; RAM is untouched.
  - Any other address writes RAM[dAddr low bits].
  - A read of the same address in the write cycle returns the old value.
- Loader states: IDLE, CNT_LO, CNT_HI, DAT_LO, DAT_HI, (CHECK), DONE.
  - A byte transfers on a rising edge with ldValid&ldReady.
  - ldReady=1 in CNT_LO, CNT_HI, DAT_LO, DAT_HI, CHECK; 0 in IDLE and DONE.
  - IDLE: ldStart=1 -> CNT_LO. cpuHold rises at that same edge. Write pointer and checksum are cleared.
  - CNT_LO/CNT_HI: capture a 16-bit little-endian word count N.
  - After CNT_HI: N==0 -> DONE (or CHECK); N>0 -> DAT_LO.
  - DAT_LO captures the low byte. DAT_HI captures the high byte, writes the word to RAM[ptr], increments ptr (wraps mod depth), and decrements remaining.
  - After the last DAT_HI: -> DONE (or CHECK).
  - N > depth: later words overwrite earlier words via wrap; this is not an error.
  - DONE: one cycle, cpuHold still 1; next edge -> IDLE with cpuHold=0.
  - The core therefore restarts from PC 0 exactly two edges after the final byte (no checksum).
- Interaction rules:
  - ldStart outside IDLE is ignored.
  - ldValid outside ldReady states is ignored; no byte is consumed.
  - While cpuHold=1: dWE is ignored and iDataOut is still driven (the core is held, so contents do not matter).
  - The loader writes RAM only in DAT_HI. No core write can coincide, since cpuHold=1.
  - rst_n low mid-load aborts immediately with the reset values above. Partially loaded RAM words remain.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Enabled:
  - The loader keeps a running XOR of every data byte (not count bytes).
  - After the last data byte (or after CNT_HI when N==0) it enters CHECK and accepts one checksum byte.
  - Match -> DONE and ldError=0.
  - Mismatch -> ldError=1 sticky, FSM -> IDLE with cpuHold kept at 1. The core stays held until a new ldStart begins a load; that ldStart clears ldError.
- Disabled:
  - No CHECK state; the FSM goes straight to DONE.
  - ldError is tied 0.

Test Plan:
- Reset then data traffic: reset -> led=0, cpuHold=0. Write dAddr=16'hFFFF, dDataIn=16'h12A5 -> led=8'hA5, dDataOut=16'h00A5. Write dAddr=16'h0010 value 16'hBEEF -> next cycle iAddr=16'h0010 gives iDataOut=16'hBEEF. dAddr=16'h0110 aliases to the same word (ADDR_BITS=8).
- Load 2 words:
  - Stimulus: ldStart, then bytes 02 00 34 12 78 56 with ldValid held.
  - Response: cpuHold=1 from the ldStart edge; RAM[0]=16'h1234, RAM[1]=16'h5678; cpuHold=0 two edges after the last byte.
  - With LOADER_CHECKSUM_EN, an extra byte 0x08 (34^12^78^56) is required and ldError stays 0.
- Backpressure: ldValid toggled 1/0 every cycle during the load above -> identical RAM result. A core dWE=1 to dAddr=0 during the load is ignored.
- Zero-count and wrap:
  - N=0 -> load completes, RAM unchanged.
  - N=257 at ADDR_BITS=8 -> word 256 overwrites RAM[0].
- Async reset mid-load: rst_n low after 3 data bytes -> immediately cpuHold=0, FSM IDLE, ldReady=0. RAM[0] keeps its newly written value.
- Checksum failure (macro on): load 1 word 16'h0001 with checksum byte 0x00 -> ldError=1, cpuHold stays 1. A new ldStart clears ldError, and a good load then releases cpuHold.
